// File: rtl/ramdrv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ramdrv_sched
//  Purpose  : Per-channel ring-buffer sequencer for the sample RAM driver.
//             For one channel per request it reads the channel's head offset
//             from the head-register bank, issues the new-sample write slot,
//             walks all filter taps newest-to-oldest with wrap-around and
//             finally advances the head. Sole master of the head-bank lines.
//  Ports    : clk, rst                  - clock, sync active-high reset
//             cfg_valid, cfg_length     - ring length load (L, ring = L+1)
//             start, start_index        - one-channel pass request
//             ready, busy, done         - status / completion pulse
//             hd_init/inc/read, hd_index, hd_length, hd_offset - head bank
//             ram_we, ram_re, ram_addr  - sample RAM {channel, offset}
//             tap_valid, tap_last, tap_num - MAC datapath qualifiers
//  Revision : 1.0 - initial release
// ============================================================================
module ramdrv_sched #(
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int VECTOR_INDEX_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cfg_valid,
  input  logic [DATA_OFFSET_WIDTH-1:0]                cfg_length,
  input  logic                                        start,
  input  logic [VECTOR_INDEX_WIDTH-1:0]               start_index,
  output logic                                        ready,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        hd_init,
  output logic                                        hd_inc,
  output logic                                        hd_read,
  output logic [VECTOR_INDEX_WIDTH-1:0]               hd_index,
  output logic [DATA_OFFSET_WIDTH-1:0]                hd_length,
  input  logic [DATA_OFFSET_WIDTH-1:0]                hd_offset,
  output logic                                        ram_we,
  output logic                                        ram_re,
  output logic [VECTOR_INDEX_WIDTH+DATA_OFFSET_WIDTH-1:0] ram_addr,
  output logic                                        tap_valid,
  output logic                                        tap_last,
  output logic [DATA_OFFSET_WIDTH-1:0]                tap_num
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFG  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_TAP  = 3'd4,
    S_INC  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                          state_q, state_d;
  logic [DATA_OFFSET_WIDTH-1:0]    len_q,  len_d;
  logic [VECTOR_INDEX_WIDTH-1:0]   idx_q,  idx_d;
  logic [DATA_OFFSET_WIDTH-1:0]    head_q, head_d;
  logic [DATA_OFFSET_WIDTH-1:0]    ptr_q,  ptr_d;
  logic [DATA_OFFSET_WIDTH-1:0]    k_q,    k_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      head_q  <= '0;
      ptr_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    head_d    = head_q;
    ptr_d     = ptr_q;
    k_d       = k_q;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    hd_init   = 1'b0;
    hd_inc    = 1'b0;
    hd_read   = 1'b0;
    hd_index  = '0;
    hd_length = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    tap_valid = 1'b0;
    tap_last  = 1'b0;
    tap_num   = '0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        // A configuration load takes priority; a coincident start is dropped.
        if (cfg_valid) begin
          len_d   = cfg_length;
          state_d = S_CFG;
        end else if (start) begin
          idx_d   = start_index;
          state_d = S_RD;
        end
      end
      S_CFG: begin
        hd_init   = 1'b1;
        hd_length = len_q;
        state_d   = S_IDLE;
      end
      S_RD: begin
        busy     = 1'b1;
        hd_read  = 1'b1;
        hd_index = idx_q;
        head_d   = hd_offset;
        state_d  = S_WR;
      end
      S_WR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = {idx_q, head_q};
        ptr_d    = head_q;
        k_d      = '0;
        state_d  = S_TAP;
      end
      S_TAP: begin
        busy      = 1'b1;
        ram_re    = 1'b1;
        tap_valid = 1'b1;
        ram_addr  = {idx_q, ptr_q};
        tap_num   = k_q;
        // Walk newest-to-oldest; offset 0 wraps back to the top of the ring.
        ptr_d     = (ptr_q == '0) ? len_q : ptr_q - 1'b1;
        k_d       = k_q + 1'b1;
        // Termination compares k against L before incrementing, so a full
        // 2**W ring ends cleanly even though k itself would wrap afterwards.
        if (k_q == len_q) begin
          tap_last = 1'b1;
          state_d  = S_INC;
        end
      end
      S_INC: begin
        busy     = 1'b1;
        hd_inc   = 1'b1;
        hd_index = idx_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ramdrv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ramdrv_sched
//  Purpose  : Self-checking bench for ramdrv_sched. A transaction-level model
//             expands each accepted request into its expected per-cycle
//             output trace; a compare process checks every cycle. A simple
//             head-bank model answers hd_read and applies hd_init/hd_inc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ramdrv_sched;
  localparam int DW  = 10;
  localparam int VW  = 4;
  localparam int NCH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [DW-1:0]  cfg_length = '0;
  logic           start = 1'b0;
  logic [VW-1:0]  start_index = '0;
  logic           ready, busy, done, hd_init, hd_inc, hd_read;
  logic [VW-1:0]  hd_index;
  logic [DW-1:0]  hd_length, hd_offset;
  logic           ram_we, ram_re, tap_valid, tap_last;
  logic [VW+DW-1:0] ram_addr;
  logic [DW-1:0]  tap_num;

  ramdrv_sched #(.DATA_OFFSET_WIDTH(DW), .VECTOR_INDEX_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_length(cfg_length),
    .start(start), .start_index(start_index), .ready(ready), .busy(busy),
    .done(done), .hd_init(hd_init), .hd_inc(hd_inc), .hd_read(hd_read),
    .hd_index(hd_index), .hd_length(hd_length), .hd_offset(hd_offset),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .tap_valid(tap_valid), .tap_last(tap_last), .tap_num(tap_num)
  );

  // ---------------- head-register bank (environment) ----------------
  logic [DW-1:0] bank_head [NCH];
  logic [DW-1:0] bank_len;
  logic [DW-1:0] garbage;
  always @(posedge clk) begin
    garbage <= DW'($urandom);
    if (rst) begin
      for (int i = 0; i < NCH; i++) bank_head[i] <= '0;
      bank_len <= '0;
    end else begin
      if (hd_init) bank_len <= hd_length;
      if (hd_inc)
        bank_head[hd_index] <= (bank_head[hd_index] == bank_len) ? '0 : bank_head[hd_index] + 1'b1;
    end
  end
  // Off-read cycles present noise so a mistimed sample shows up as a wrong head.
  assign hd_offset = hd_read ? bank_head[hd_index] : garbage;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic ready, busy, done, hd_init, hd_inc, hd_read;
    logic [VW-1:0] hd_index;
    logic [DW-1:0] hd_length;
    logic ram_we, ram_re;
    logic [VW+DW-1:0] ram_addr;
    logic tap_valid, tap_last;
    logic [DW-1:0] tap_num;
  } obs_t;

  obs_t eq[$];
  int   m_head[NCH];
  int   m_len = 0;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = -1;
  bit chk_en = 1'b0, cur_idle = 1'b1;
  logic [DW-1:0] tap_cap[$];
  logic [DW-1:0] head_cap[$];
  obs_t a_o, e_o;

  function automatic obs_t idle_o();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Address/data fields only carry meaning while their strobe is high.
  function automatic obs_t mask(input obs_t o);
    obs_t m = o;
    if (!(m.hd_read || m.hd_inc)) m.hd_index = '0;
    if (!m.hd_init) m.hd_length = '0;
    if (!(m.ram_we || m.ram_re)) m.ram_addr = '0;
    if (!m.tap_valid) m.tap_num = '0;
    return m;
  endfunction

  function automatic logic [VW+DW-1:0] addr_of(input int ch, input int off);
    return (VW+DW)'((ch << DW) + off);
  endfunction

  task automatic push_pass(input int idx);
    obs_t o;
    int h, off;
    h = m_head[idx];
    o = '0; o.busy = 1; o.hd_read = 1; o.hd_index = VW'(idx); eq.push_back(o);
    o = '0; o.busy = 1; o.ram_we = 1; o.ram_addr = addr_of(idx, h); eq.push_back(o);
    for (int k = 0; k <= m_len; k++) begin
      off = (h >= k) ? h - k : h - k + m_len + 1;
      o = '0; o.busy = 1; o.ram_re = 1; o.tap_valid = 1;
      o.ram_addr = addr_of(idx, off); o.tap_num = DW'(k); o.tap_last = (k == m_len);
      eq.push_back(o);
    end
    o = '0; o.busy = 1; o.hd_inc = 1; o.hd_index = VW'(idx); eq.push_back(o);
    o = '0; o.busy = 1; o.done = 1; eq.push_back(o);
    m_head[idx] = (h == m_len) ? 0 : h + 1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (chk_en) begin
      a_o = '0;
      a_o.ready = ready; a_o.busy = busy; a_o.done = done;
      a_o.hd_init = hd_init; a_o.hd_inc = hd_inc; a_o.hd_read = hd_read;
      a_o.hd_index = hd_index; a_o.hd_length = hd_length;
      a_o.ram_we = ram_we; a_o.ram_re = ram_re; a_o.ram_addr = ram_addr;
      a_o.tap_valid = tap_valid; a_o.tap_last = tap_last; a_o.tap_num = tap_num;
      if (eq.size() > 0) begin
        e_o = eq.pop_front();
        cur_idle = 1'b0;
      end else begin
        e_o = idle_o();
        cur_idle = 1'b1;
      end
      n_cmp++;
      if (mask(a_o) !== mask(e_o)) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got %h want %h", cyc, mask(a_o), mask(e_o));
      end
      if (tap_valid) tap_cap.push_back(ram_addr[DW-1:0]);
      if (hd_read) head_cap.push_back(hd_offset);
      if (done) done_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the model at the edge that samples them.
  task automatic step(input bit cv, input int cl, input bit st, input int si, input bit r);
    obs_t o;
    @(negedge clk); #1;
    cfg_valid = cv; cfg_length = DW'(cl); start = st; start_index = VW'(si); rst = r;
    @(posedge clk);
    if (r) begin
      eq.delete();
      for (int i = 0; i < NCH; i++) m_head[i] = 0;
      m_len = 0;
    end else if (cur_idle) begin
      if (cv) begin
        m_len = cl;
        o = '0; o.hd_init = 1; o.hd_length = DW'(cl);
        eq.push_back(o);
      end else if (st) begin
        acc_cyc = cyc;
        push_pass(si);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic pass(input int idx);
    step(0, 0, 1, idx, 0);
    idle(m_len + 5);
  endtask

  function automatic int max_head();
    int m = 0;
    for (int i = 0; i < NCH; i++) if (m_head[i] > m) m = m_head[i];
    return m;
  endfunction

  int rsel, cl;

  initial begin
    for (int i = 0; i < NCH; i++) m_head[i] = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0);
    #2;
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset tap_num", tap_num, 0);
    chk("reset hd_index", hd_index, 0);

    // Length load
    step(1, 3, 0, 0, 0);
    #2;
    chk("cfg hd_init", hd_init, 1);
    chk("cfg hd_length", hd_length, 3);
    step(0, 0, 0, 0, 0);
    #2;
    chk("cfg ready after", ready, 1);
    chk("cfg hd_init after", hd_init, 0);

    // Five passes on channel 2
    tap_cap.delete(); head_cap.delete();
    pass(2);
    chk("L3 done latency", done_cyc - acc_cyc, 8);
    chk("L3 tap0", tap_cap[0], 0);
    chk("L3 tap1", tap_cap[1], 3);
    chk("L3 tap2", tap_cap[2], 2);
    chk("L3 tap3", tap_cap[3], 1);
    for (int p = 0; p < 4; p++) pass(2);
    chk("head cap 0", head_cap[0], 0);
    chk("head cap 1", head_cap[1], 1);
    chk("head cap 2", head_cap[2], 2);
    chk("head cap 3", head_cap[3], 3);
    chk("head cap 4", head_cap[4], 0);
    chk("head1 tap0", tap_cap[4], 1);
    chk("head1 tap1", tap_cap[5], 0);
    chk("head1 tap2", tap_cap[6], 3);
    chk("head1 tap3", tap_cap[7], 2);

    // Interleaved channels
    head_cap.delete();
    pass(5); pass(2); pass(5); pass(2);
    chk("alt head5 a", head_cap[0], 0);
    chk("alt head2 a", head_cap[1], 1);
    chk("alt head5 b", head_cap[2], 1);
    chk("alt head2 b", head_cap[3], 2);

    // cfg and start together: start dropped
    step(1, 3, 1, 4, 0);
    #2;
    chk("cfg+start hd_init", hd_init, 1);
    chk("cfg+start busy", busy, 0);
    idle(3);

    // Reset during taps
    step(0, 0, 1, 2, 0);
    idle(3);
    step(0, 0, 0, 0, 1);
    #2;
    chk("abort ready", ready, 1);
    chk("abort tap_valid", tap_valid, 0);
    chk("abort ram_re", ram_re, 0);
    step(0, 0, 0, 0, 0);
    tap_cap.delete(); head_cap.delete();
    pass(2);
    chk("post-rst head", head_cap[0], 0);
    chk("L0 tap count", tap_cap.size(), 1);
    chk("L0 tap off", tap_cap[0], 0);
    chk("L0 done latency", done_cyc - acc_cyc, 5);
    pass(2);
    chk("L0 head stays", head_cap[1], 0);

    // Full ring
    step(1, 1023, 0, 0, 0);
    idle(2);
    tap_cap.delete();
    pass(7);
    chk("full ring taps", tap_cap.size(), 1024);
    chk("full ring wrap", tap_cap[1], 1023);
    chk("full ring done", done_cyc - acc_cyc, 1028);
    step(0, 0, 0, 0, 1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      rsel = $urandom_range(0, 99);
      cl = max_head() + $urandom_range(0, 15 - max_head());
      if (rsel < 2)       step($urandom_range(0, 1), cl, $urandom_range(0, 1), $urandom_range(0, NCH-1), 1);
      else if (rsel < 12) step(1, cl, $urandom_range(0, 1), $urandom_range(0, NCH-1), 0);
      else if (rsel < 70) step(0, cl, 1, $urandom_range(0, NCH-1), 0);
      else                step(0, cl, 0, $urandom_range(0, NCH-1), 0);
    end
    idle(30);
    chk("model drained", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ramdrv_sched.md
Name: ramdrv_sched

Overview:
- Per-channel ring-buffer sequencer for the sample RAM driver.
- For one channel per request, it:
  - reads the channel's head offset from the head-register bank,
  - issues the new-sample write slot,
  - walks all filter taps newest-to-oldest with wrap-around,
  - advances the head.
- Sits between the SRC core controller (requester) and the head-register bank plus sample RAM.
- It is the only master of the head-bank command lines.

Parameters:
DATA_OFFSET_WIDTH, 10, width of ring offsets, lengths and tap counts
VECTOR_INDEX_WIDTH, 4, width of channel index; 2**VECTOR_INDEX_WIDTH channels

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cfg_valid  input  1  load new ring length (honoured only when ready=1)
cfg_length  input  DATA_OFFSET_WIDTH  last valid offset L; ring holds L+1 entries
start  input  1  request one channel pass (honoured only when ready=1 and cfg_valid=0)
start_index  input  VECTOR_INDEX_WIDTH  channel to process
ready  output  1  scheduler idle, request may be issued
busy  output  1  pass in progress
done  output  1  one-cycle pulse, pass complete
hd_init  output  1  head bank: load length
hd_inc  output  1  head bank: increment head[hd_index]
hd_read  output  1  head bank: drive head[hd_index]
hd_index  output  VECTOR_INDEX_WIDTH  head bank channel select
hd_length  output  DATA_OFFSET_WIDTH  head bank length value
hd_offset  input  DATA_OFFSET_WIDTH  head bank read data; high-Z unless hd_read=1
ram_we  output  1  write incoming sample at ram_addr
ram_re  output  1  read tap sample at ram_addr
ram_addr  output  VECTOR_INDEX_WIDTH+DATA_OFFSET_WIDTH  {channel, offset}
tap_valid  output  1  ram_re cycle qualifier for MAC datapath
tap_last  output  1  final tap of pass
tap_num  output  DATA_OFFSET_WIDTH  tap index k, 0..L

Behaviour:
Reset (synchronous, rst=1 on a clk edge):
- State goes to IDLE.
- All strobes (done, hd_*, ram_*, tap_*) are 0; busy=0; ready=1.
- hd_index, hd_length, ram_addr, tap_num and the internal len_q/head_q/ptr are 0.
- rst during any state aborts the pass next edge; no further strobes are issued.
- The head bank shares rst, so all heads restart at 0.

Command lines:
- At most one of hd_init/hd_inc/hd_read is high in any cycle.
- hd_offset is sampled only while hd_read=1.

States:
- IDLE: ready=1.
  - cfg_valid=1 -> CFG; len_q<=cfg_length.
  - Else start=1 -> RD; idx_q<=start_index.
  - cfg_valid wins over start in the same cycle; the start is dropped, not queued.
- CFG: hd_init=1, hd_length=len_q for one cycle -> IDLE.
- RD: hd_read=1, hd_index=idx_q; head_q<=hd_offset -> WR.
- WR: ram_we=1, ram_addr={idx_q,head_q}; ptr<=head_q, k<=0 -> TAP.
- TAP: ram_re=tap_valid=1, ram_addr={idx_q,ptr}, tap_num=k.
  - ptr<=(ptr==0)?len_q:ptr-1; k<=k+1.
  - When k==len_q: tap_last=1 -> INC.
- INC: hd_inc=1, hd_index=idx_q -> DONE.
  - The bank wraps head to 0 after head==L.
- DONE: done=1 -> IDLE.

Status and latency:
- busy=1 in RD..DONE.
- ready=1 only in IDLE.
- With accept at cycle 0: RD at 1, WR at 2, taps at 3..L+3, INC at L+4, done at L+5; next accept possible at L+6.
- Each pass issues L+1 taps, so tap offsets are head, head-1, …, wrapping 0->L.

Arithmetic and boundaries:
- All offset arithmetic is unsigned DATA_OFFSET_WIDTH; no carry beyond width.
- L=0: single tap at offset 0; head stays 0.
- L = 2**DATA_OFFSET_WIDTH-1 is legal: full ring; k never overflows before tap_last.
- Changing cfg_length does not reset the heads. A head currently greater than the new L is the requester's responsibility; the sequencer still emits exactly L+1 taps.

Test Plan:
- Reset, then cfg_valid with cfg_length=3 -> hd_init=1 for exactly one cycle with hd_length=3; ready=1 the cycle after; no other strobe.
- L=3, start idx=2 at cycle 0 (head 0):
  - hd_read at 1; ram_we addr {2,0} at 2;
  - taps offsets 0,3,2,1 at 3..6, tap_num 0..3, tap_last at 6;
  - hd_inc at 7; done at 8.
- Five consecutive passes on idx 2 -> captured heads 0,1,2,3,0; pass with head=1 gives taps 1,0,3,2.
- Alternate passes on idx 5 and idx 2 -> each channel's head advances independently; ram_addr upper bits track the channel.
- cfg_valid and start same cycle in IDLE -> only CFG runs; busy never rises; start ignored.
- rst asserted mid-TAP -> next cycle all strobes 0, ready=1; following start on that channel captures head 0. L=0 pass -> one tap at offset 0, done at accept+5.
